// File: rtl/fifo_wr_flow_ctl_if.sv
// Stream-side and FIFO-write-side handshake bundle of the LCD FIFO write controller.
interface fifo_wr_flow_ctl_if #(
  parameter int unsigned CNT_W = 10
);
  logic             axis_data_en;
  logic             axis_data_sync;
  logic             axis_data_requst;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_wr_cnt;
  logic             lcd_framesync;

  // master: stream source plus FIFO status; slave: the flow controller
  modport master (
    output axis_data_en, axis_data_sync, fifo_full, fifo_wr_cnt,
    input  axis_data_requst, fifo_wr_en, lcd_framesync
  );

  modport slave (
    input  axis_data_en, axis_data_sync, fifo_full, fifo_wr_cnt,
    output axis_data_requst, fifo_wr_en, lcd_framesync
  );
endinterface

// File: rtl/fifo_wr_flow_ctl.sv
// LCD line FIFO write controller: watermark-throttled stream request, frame-sync
// alignment, overflow and frame-length detection with resync to the next frame.
module fifo_wr_flow_ctl #(
  parameter int unsigned CNT_W                  = 10,
  parameter int unsigned FIFO_ALMOSTFULL_DEPTH  = 768,
  parameter int unsigned FIFO_ALMOSTEMPTY_DEPTH = 128,
  parameter int unsigned FRAME_PIXELS           = 384000,
  parameter int unsigned PIX_W                  = 20
) (
  input  logic              fifo_wr_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr_flags,
  fifo_wr_flow_ctl_if.slave bus,
  output logic              ovf_flag,
  output logic              frame_err_flag,
  output logic [PIX_W-1:0]  pix_cnt
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_STREAM    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(FIFO_ALMOSTFULL_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AEMPTY = CNT_W'(FIFO_ALMOSTEMPTY_DEPTH);
  localparam logic [PIX_W-1:0] FRAME_LEN  = PIX_W'(FRAME_PIXELS);
  localparam logic [PIX_W-1:0] PIX_MAX    = '1;

  logic [1:0]       state_q, state_d;
  logic             requst_q, requst_d;
  logic             wr_ready_q, wr_ready_d;
  logic             fsync_q, fsync_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             beat_c;
  logic             wr_en_c;
  logic             ovf_evt;
  logic             err_evt;

  // Write strobe: only a sync beat in WAIT_SYNC, any accepted beat in STREAM
  always_comb begin
    beat_c  = requst_q & bus.axis_data_en;
    wr_en_c = 1'b0;
    case (state_q)
      ST_WAIT_SYNC: wr_en_c = beat_c & bus.axis_data_sync & ~bus.fifo_full;
      ST_STREAM:    wr_en_c = beat_c & ~bus.fifo_full;
      default:      wr_en_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    fsync_d = 1'b0;
    ovf_evt = 1'b0;
    err_evt = 1'b0;

    // Hysteresis between the two watermarks, tracked regardless of state
    if (bus.fifo_wr_cnt < CNT_AEMPTY) begin
      wr_ready_d = 1'b1;
    end else if (bus.fifo_wr_cnt >= CNT_AFULL) begin
      wr_ready_d = 1'b0;
    end else begin
      wr_ready_d = wr_ready_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (wr_en_c) begin
          state_d = ST_STREAM;
          pix_d   = PIX_W'(1);
          fsync_d = 1'b1;
        end
      end
      ST_STREAM: begin
        if (wr_en_c && bus.axis_data_sync) begin
          err_evt = (pix_q != FRAME_LEN);
          pix_d   = PIX_W'(1);
          fsync_d = 1'b1;
        end else if (wr_en_c) begin
          // Beat beyond the expected length is kept but the frame is abandoned
          if (pix_q == FRAME_LEN) begin
            err_evt = 1'b1;
            state_d = ST_WAIT_SYNC;
          end
          pix_d = (pix_q == PIX_MAX) ? pix_q : pix_q + PIX_W'(1);
        end else if (beat_c && bus.fifo_full) begin
          ovf_evt = 1'b1;
          state_d = ST_WAIT_SYNC;
          pix_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WAIT_SYNC: requst_d = 1'b1;
      ST_STREAM:    requst_d = wr_ready_d;
      default:      requst_d = 1'b0;
    endcase

    if (!enable) begin
      state_d  = ST_IDLE;
      requst_d = 1'b0;
      pix_d    = '0;
    end

    ovf_d = ovf_evt | (ovf_q & ~clr_flags);
    err_d = err_evt | (err_q & ~clr_flags);
  end

  always_ff @(posedge fifo_wr_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      requst_q   <= 1'b0;
      wr_ready_q <= 1'b0;
      fsync_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      requst_q   <= requst_d;
      wr_ready_q <= wr_ready_d;
      fsync_q    <= fsync_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      pix_q      <= pix_d;
    end
  end

  assign bus.axis_data_requst = requst_q;
  assign bus.fifo_wr_en       = wr_en_c;
  assign bus.lcd_framesync    = fsync_q;
  assign ovf_flag             = ovf_q;
  assign frame_err_flag       = err_q;
  assign pix_cnt              = pix_q;

endmodule

// File: tb/tb_fifo_wr_flow_ctl.sv
// Bench for fifo_wr_flow_ctl: directed scenarios plus random traffic against a frame-level model.
module tb_fifo_wr_flow_ctl;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned AF    = 768;
  localparam int unsigned AE    = 128;
  localparam int unsigned FP    = 48;
  localparam int unsigned PIX_W = 6;
  localparam int PIX_MAX = (1 << PIX_W) - 1;
  localparam int M_IDLE = 0, M_HUNT = 1, M_STREAM = 2;

  logic clk = 1'b0;
  logic rst;
  logic enable = 1'b0;
  logic clr_flags = 1'b0;
  logic ovf_flag, frame_err_flag;
  logic [PIX_W-1:0] pix_cnt;
  int n_total = 0;
  int n_bad = 0;

  fifo_wr_flow_ctl_if #(.CNT_W(CNT_W)) bus ();

  fifo_wr_flow_ctl #(
    .CNT_W(CNT_W), .FIFO_ALMOSTFULL_DEPTH(AF), .FIFO_ALMOSTEMPTY_DEPTH(AE),
    .FRAME_PIXELS(FP), .PIX_W(PIX_W)
  ) dut (
    .fifo_wr_clk(clk), .rst(rst), .enable(enable), .clr_flags(clr_flags), .bus(bus),
    .ovf_flag(ovf_flag), .frame_err_flag(frame_err_flag), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: which phase of a frame we are in, how many beats it has, flags
  int m_mode;
  int m_cnt;
  bit m_req, m_ready, m_fs, m_ovf, m_err;

  function automatic bit model_wr();
    if (m_mode == M_HUNT)   return bus.axis_data_en && bus.axis_data_sync && !bus.fifo_full;
    if (m_mode == M_STREAM) return m_req && bus.axis_data_en && !bus.fifo_full;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0;
    m_req = 0; m_ready = 0; m_fs = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit wr = model_wr();
    bit rdy;
    bit s_ovf = 0, s_err = 0, fs = 0;
    int mode_n = m_mode;
    int cnt_n = m_cnt;
    int fill = int'(bus.fifo_wr_cnt);
    rdy = (fill < AE) ? 1'b1 : (fill >= AF) ? 1'b0 : m_ready;
    if (m_mode == M_IDLE && enable) mode_n = M_HUNT;
    if (m_mode == M_HUNT && wr) begin
      mode_n = M_STREAM; cnt_n = 1; fs = 1;
    end
    if (m_mode == M_STREAM) begin
      if (wr && bus.axis_data_sync) begin
        s_err = (m_cnt != FP); cnt_n = 1; fs = 1;
      end else if (wr) begin
        if (m_cnt == FP) begin s_err = 1; mode_n = M_HUNT; end
        cnt_n = (m_cnt == PIX_MAX) ? m_cnt : m_cnt + 1;
      end else if (m_req && bus.axis_data_en && bus.fifo_full) begin
        s_ovf = 1; mode_n = M_HUNT; cnt_n = 0;
      end
    end
    m_req = (mode_n == M_HUNT) || (mode_n == M_STREAM && rdy);
    if (!enable) begin mode_n = M_IDLE; m_req = 0; cnt_n = 0; end
    m_ovf = s_ovf || (m_ovf && !clr_flags);
    m_err = s_err || (m_err && !clr_flags);
    m_fs = fs; m_ready = rdy; m_mode = mode_n; m_cnt = cnt_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic beats(input int n);
    bus.axis_data_en = 1'b1; bus.axis_data_sync = 1'b0;
    repeat (n) tick();
    bus.axis_data_en = 1'b0;
  endtask

  task automatic sync_beat();
    bus.axis_data_en = 1'b1; bus.axis_data_sync = 1'b1;
    tick();
    bus.axis_data_en = 1'b0; bus.axis_data_sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.axis_data_en = 0; bus.axis_data_sync = 0; bus.fifo_full = 0; bus.fifo_wr_cnt = '0;
    model_reset();
    #2;
    n_total++; if (bus.axis_data_requst !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", bus.axis_data_requst); end
    n_total++; if (bus.lcd_framesync !== 1'b0) begin n_bad++; $display("FAIL reset_fs got %b want 0", bus.lcd_framesync); end
    n_total++; if ({ovf_flag, frame_err_flag} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {ovf_flag, frame_err_flag}); end
    n_total++; if (pix_cnt !== '0) begin n_bad++; $display("FAIL reset_pix got %0d want 0", pix_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sync_align();
    enable = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus.axis_data_en = 1'b1; bus.axis_data_sync = (i == 3);
      #1;
      n_total++; if (bus.fifo_wr_en !== (i >= 3)) begin n_bad++; $display("FAIL align_wr beat %0d got %b want %b", i, bus.fifo_wr_en, (i >= 3)); end
      tick();
      if (i == 3 || i == 4) begin
        n_total++; if (bus.lcd_framesync !== (i == 3)) begin n_bad++; $display("FAIL align_fs beat %0d got %b want %b", i, bus.lcd_framesync, (i == 3)); end
      end
    end
    bus.axis_data_en = 1'b0; bus.axis_data_sync = 1'b0;
    n_total++; if (pix_cnt !== PIX_W'(3)) begin n_bad++; $display("FAIL align_pix got %0d want 3", pix_cnt); end
  endtask

  task automatic test_watermark();
    bus.fifo_wr_cnt = 10'd767; tick();
    n_total++; if (bus.axis_data_requst !== 1'b1) begin n_bad++; $display("FAIL wm_767 got %b want 1", bus.axis_data_requst); end
    bus.fifo_wr_cnt = 10'd768; #1;
    n_total++; if (bus.axis_data_requst !== 1'b1) begin n_bad++; $display("FAIL wm_latency got %b want 1", bus.axis_data_requst); end
    tick();
    n_total++; if (bus.axis_data_requst !== 1'b0) begin n_bad++; $display("FAIL wm_768 got %b want 0", bus.axis_data_requst); end
    bus.fifo_wr_cnt = 10'd200; tick(); tick();
    n_total++; if (bus.axis_data_requst !== 1'b0) begin n_bad++; $display("FAIL wm_200 got %b want 0", bus.axis_data_requst); end
    bus.fifo_wr_cnt = 10'd128; tick();
    n_total++; if (bus.axis_data_requst !== 1'b0) begin n_bad++; $display("FAIL wm_128 got %b want 0", bus.axis_data_requst); end
    bus.fifo_wr_cnt = 10'd127; tick();
    n_total++; if (bus.axis_data_requst !== 1'b1) begin n_bad++; $display("FAIL wm_127 got %b want 1", bus.axis_data_requst); end
  endtask

  task automatic test_overshoot();
    bus.fifo_wr_cnt = 10'd700; tick();
    n_total++; if (bus.axis_data_requst !== 1'b1) begin n_bad++; $display("FAIL os_700 got %b want 1", bus.axis_data_requst); end
    bus.fifo_wr_cnt = 10'd800; tick();
    n_total++; if (bus.axis_data_requst !== 1'b0) begin n_bad++; $display("FAIL os_800 got %b want 0", bus.axis_data_requst); end
    bus.fifo_wr_cnt = 10'd0; tick();
    n_total++; if (bus.axis_data_requst !== 1'b1) begin n_bad++; $display("FAIL os_0 got %b want 1", bus.axis_data_requst); end
  endtask

  task automatic test_frame_len();
    sync_beat();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    n_total++; if (frame_err_flag !== 1'b0) begin n_bad++; $display("FAIL fl_clr got %b want 0", frame_err_flag); end
    beats(11);
    clr_flags = 1'b1; sync_beat(); clr_flags = 1'b0;
    n_total++; if (frame_err_flag !== 1'b1) begin n_bad++; $display("FAIL fl_short got %b want 1", frame_err_flag); end
    n_total++; if (pix_cnt !== PIX_W'(1)) begin n_bad++; $display("FAIL fl_restart got %0d want 1", pix_cnt); end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    beats(FP - 1);
    n_total++; if (pix_cnt !== PIX_W'(FP)) begin n_bad++; $display("FAIL fl_count got %0d want %0d", pix_cnt, FP); end
    sync_beat();
    n_total++; if (frame_err_flag !== 1'b0) begin n_bad++; $display("FAIL fl_exact got %b want 0", frame_err_flag); end
    beats(FP - 1);
    bus.axis_data_en = 1'b1; #1;
    n_total++; if (bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL fl_long_wr got %b want 1", bus.fifo_wr_en); end
    tick();
    n_total++; if (frame_err_flag !== 1'b1) begin n_bad++; $display("FAIL fl_long got %b want 1", frame_err_flag); end
    #1;
    n_total++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL fl_resync_wr got %b want 0", bus.fifo_wr_en); end
    tick();
    bus.axis_data_en = 1'b0;
  endtask

  task automatic test_overflow();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    sync_beat();
    beats(4);
    bus.fifo_full = 1'b1; bus.axis_data_en = 1'b1; #1;
    n_total++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL ovf_wr got %b want 0", bus.fifo_wr_en); end
    tick();
    n_total++; if (ovf_flag !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", ovf_flag); end
    n_total++; if (pix_cnt !== '0) begin n_bad++; $display("FAIL ovf_pix got %0d want 0", pix_cnt); end
    bus.fifo_full = 1'b0; #1;
    n_total++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL ovf_nosync got %b want 0", bus.fifo_wr_en); end
    tick();
    bus.axis_data_sync = 1'b1; #1;
    n_total++; if (bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL ovf_sync got %b want 1", bus.fifo_wr_en); end
    tick();
    bus.axis_data_en = 1'b0; bus.axis_data_sync = 1'b0;
    n_total++; if (bus.lcd_framesync !== 1'b1) begin n_bad++; $display("FAIL ovf_fs got %b want 1", bus.lcd_framesync); end
  endtask

  task automatic test_reset_mid();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    beats(39);
    n_total++; if (pix_cnt !== PIX_W'(40)) begin n_bad++; $display("FAIL rm_pix got %0d want 40", pix_cnt); end
    bus.axis_data_en = 1'b1; rst = 1'b1; model_reset(); #1;
    n_total++; if ({bus.axis_data_requst, bus.fifo_wr_en, bus.lcd_framesync, pix_cnt} !== '0) begin
      n_bad++; $display("FAIL rm_async got req=%b wr=%b pix=%0d want 0", bus.axis_data_requst, bus.fifo_wr_en, pix_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.axis_data_en = 1'b0;
    tick();
    bus.axis_data_en = 1'b1; #1;
    n_total++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL rm_nosync got %b want 0", bus.fifo_wr_en); end
    tick();
    bus.axis_data_sync = 1'b1; #1;
    n_total++; if (bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL rm_sync got %b want 1", bus.fifo_wr_en); end
    tick();
    bus.axis_data_en = 1'b0; bus.axis_data_sync = 1'b0;
  endtask

  task automatic test_enable_drop();
    bus.axis_data_en = 1'b1; enable = 1'b0; #1;
    n_total++; if (bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL en_inflight got %b want 1", bus.fifo_wr_en); end
    tick();
    n_total++; if ({bus.axis_data_requst, pix_cnt} !== '0) begin n_bad++; $display("FAIL en_idle got req=%b pix=%0d want 0", bus.axis_data_requst, pix_cnt); end
    n_total++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL en_idle_wr got %b want 0", bus.fifo_wr_en); end
    tick();
    bus.axis_data_en = 1'b0; enable = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) != 0);
      bus.axis_data_en = $urandom_range(0, 1);
      bus.axis_data_sync = ($urandom_range(0, 39) == 0);
      bus.fifo_full = ($urandom_range(0, 19) == 0);
      bus.fifo_wr_cnt = CNT_W'($urandom_range(0, 1023));
      clr_flags = ($urandom_range(0, 29) == 0);
      #1;
      n_total++; if (bus.fifo_wr_en !== model_wr()) begin n_bad++; $display("FAIL rnd_wr cyc %0d got %b want %b", i, bus.fifo_wr_en, model_wr()); end
      tick();
      n_total++; if (bus.axis_data_requst !== m_req) begin n_bad++; $display("FAIL rnd_req cyc %0d got %b want %b", i, bus.axis_data_requst, m_req); end
      n_total++; if (bus.lcd_framesync !== m_fs) begin n_bad++; $display("FAIL rnd_fs cyc %0d got %b want %b", i, bus.lcd_framesync, m_fs); end
      n_total++; if ({ovf_flag, frame_err_flag} !== {m_ovf, m_err}) begin n_bad++; $display("FAIL rnd_flags cyc %0d got %b%b want %b%b", i, ovf_flag, frame_err_flag, m_ovf, m_err); end
      n_total++; if (pix_cnt !== PIX_W'(m_cnt)) begin n_bad++; $display("FAIL rnd_pix cyc %0d got %0d want %0d", i, pix_cnt, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_sync_align();
    test_watermark();
    test_overshoot();
    test_frame_len();
    test_overflow();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
